// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input front-end.
package arcade_input_pkg;

    // Coin shaper states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_LOCK  = 2'd2
    } coin_state_e;

    // Bit positions inside a MiSTer joystick word
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;

    // hps_io download index conventionally used for DIP switch data
    localparam int DSW_INDEX_DEFAULT = 254;

endpackage

// File: rtl/arcade_input_ctrl_coin_shaper.sv
// Single-channel coin shaper: one fixed-width pulse per accepted rising edge,
// followed by a lockout window during which further edges are discarded.
module coin_shaper
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 50000,
    parameter int unsigned COIN_LOCK  = 200000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic coin_i,
    output logic coin_o
);

    // Counter only needs to reach the longer of the two intervals minus one.
    localparam int unsigned CNT_MAX = (COIN_PULSE > COIN_LOCK) ? COIN_PULSE : COIN_LOCK;
    localparam int          CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = (COIN_LOCK == 0) ? '0 : CNT_W'(COIN_LOCK - 1);

    coin_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_q;
    logic             prev_q;
    logic             rise;

    assign rise = in_q & ~prev_q;

    // State, interval counter and two-deep coin history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            in_q    <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= coin_i;
            prev_q  <= in_q;
        end
    end

    // Next state: only IDLE listens to edges, so edges during PULSE/LOCK are lost
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (COIN_LOCK == 0) ? ST_IDLE : ST_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCK: begin
                if (cnt_q == LOCK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output: coin is active exactly while in PULSE
    always_comb begin
        coin_o = (state_q == ST_PULSE);
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Joystick / DIP front-end between hps_io and an arcade core: registered
// directions with opposite-pair cancellation, autofire, coin shaping and DIP capture.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned NUM_BTN     = 3,
    parameter int unsigned DSW_BYTES   = 8,
    parameter logic [7:0]  DSW_INDEX   = 8'(DSW_INDEX_DEFAULT),
    parameter logic [7:0]  DSW_DEFAULT = 8'hFF,
    parameter int unsigned COIN_BIT    = 8,
    parameter int unsigned COIN_PULSE  = 50000,
    parameter int unsigned COIN_LOCK   = 200000,
    parameter int unsigned AF_DIV      = 400000,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic [NUM_PLAYERS*16-1:0]      joy,
    input  logic [NUM_PLAYERS*NUM_BTN-1:0] af_en,
    input  logic                           ioctl_wr,
    input  logic [7:0]                     ioctl_index,
    input  logic [26:0]                    ioctl_addr,
    input  logic [7:0]                     ioctl_dout,
    output logic [NUM_PLAYERS*4-1:0]       dir_out,
    output logic [NUM_PLAYERS*NUM_BTN-1:0] btn_out,
    output logic [NUM_PLAYERS-1:0]         coin_out,
    output logic [DSW_BYTES*8-1:0]         dsw,
    output logic                           dsw_valid
);

    localparam logic [19:0] AF_LAST = 20'(AF_DIV - 1);

    logic [DSW_BYTES*8-1:0]         dsw_q;
    logic                           dsw_valid_q;
    logic                           dsw_hit;
    logic [19:0]                    af_cnt_q;
    logic                           af_phase_q;
    logic [NUM_PLAYERS*4-1:0]       dir_d, dir_q;
    logic [NUM_PLAYERS*NUM_BTN-1:0] btn_d, btn_q;
    logic [NUM_PLAYERS-1:0]         coin_raw;
    logic                           unused_joy;

    // Only a handful of joystick bits are consumed; fold the rest away.
    assign unused_joy = ^joy;

    assign dsw_hit = ioctl_wr && (ioctl_index == DSW_INDEX) &&
                     (ioctl_addr < 27'(DSW_BYTES));

    // DIP byte capture; any accepted write marks the set as valid
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dsw_q       <= {DSW_BYTES{DSW_DEFAULT}};
            dsw_valid_q <= 1'b0;
        end else if (dsw_hit) begin
            for (int i = 0; i < int'(DSW_BYTES); i++) begin
                if (ioctl_addr == 27'(i)) begin
                    dsw_q[8*i +: 8] <= ioctl_dout;
                end
            end
            dsw_valid_q <= 1'b1;
        end
    end

    // Shared autofire prescaler; phase flips every AF_DIV cycles
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else if (af_cnt_q == AF_LAST) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q <= af_cnt_q + 20'd1;
        end
    end

    genvar gi, gb;
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [15:0] j;
        assign j = joy[16*gi +: 16];

        // Opposite directions pressed together cancel each other
        assign dir_d[4*gi + JOY_RIGHT] = j[JOY_RIGHT] & ~j[JOY_LEFT];
        assign dir_d[4*gi + JOY_LEFT]  = j[JOY_LEFT]  & ~j[JOY_RIGHT];
        assign dir_d[4*gi + JOY_DOWN]  = j[JOY_DOWN]  & ~j[JOY_UP];
        assign dir_d[4*gi + JOY_UP]    = j[JOY_UP]    & ~j[JOY_DOWN];

        // Autofire gates a held button with the shared phase
        for (gb = 0; gb < NUM_BTN; gb++) begin : g_btn
            assign btn_d[gi*NUM_BTN + gb] =
                j[JOY_BTN0 + gb] & (~af_en[gi*NUM_BTN + gb] | af_phase_q);
        end

        coin_shaper #(
            .COIN_PULSE (COIN_PULSE),
            .COIN_LOCK  (COIN_LOCK)
        ) u_coin (
            .clk_i  (clk_sys),
            .rst_ni (reset_n),
            .coin_i (j[COIN_BIT]),
            .coin_o (coin_raw[gi])
        );
    end

    // Output registers for directions and buttons, polarity applied before the flop
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_q <= {(NUM_PLAYERS*4){ACTIVE_LOW}};
            btn_q <= {(NUM_PLAYERS*NUM_BTN){ACTIVE_LOW}};
        end else begin
            dir_q <= dir_d ^ {(NUM_PLAYERS*4){ACTIVE_LOW}};
            btn_q <= btn_d ^ {(NUM_PLAYERS*NUM_BTN){ACTIVE_LOW}};
        end
    end

    assign dir_out   = dir_q;
    assign btn_out   = btn_q;
    assign coin_out  = coin_raw ^ {NUM_PLAYERS{ACTIVE_LOW}};
    assign dsw       = dsw_q;
    assign dsw_valid = dsw_valid_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: a cycle-level model checked every cycle against an
// active-high and an active-low instance, plus directed hand-computed checks.
module tb_arcade_input_ctrl;

    localparam int NP  = 2;
    localparam int NB  = 3;
    localparam int DB  = 8;
    localparam int CP  = 4;
    localparam int CL  = 6;
    localparam int AFD = 3;
    localparam int CB  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP*16-1:0]  joy = '0;
    logic [NP*NB-1:0]  af_en = '0;
    logic              ioctl_wr = 1'b0;
    logic [7:0]        ioctl_index = '0;
    logic [26:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;

    logic [NP*4-1:0]   dir_out, dir_out_al;
    logic [NP*NB-1:0]  btn_out, btn_out_al;
    logic [NP-1:0]     coin_out, coin_out_al;
    logic [DB*8-1:0]   dsw, dsw_al;
    logic              dsw_valid, dsw_valid_al;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    arcade_input_ctrl #(
        .NUM_PLAYERS(NP), .NUM_BTN(NB), .DSW_BYTES(DB), .COIN_BIT(CB),
        .COIN_PULSE(CP), .COIN_LOCK(CL), .AF_DIV(AFD), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk_sys(clk), .reset_n(reset_n), .joy(joy), .af_en(af_en),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .dir_out(dir_out), .btn_out(btn_out),
        .coin_out(coin_out), .dsw(dsw), .dsw_valid(dsw_valid)
    );

    arcade_input_ctrl #(
        .NUM_PLAYERS(NP), .NUM_BTN(NB), .DSW_BYTES(DB), .COIN_BIT(CB),
        .COIN_PULSE(CP), .COIN_LOCK(CL), .AF_DIV(AFD), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk_sys(clk), .reset_n(reset_n), .joy(joy), .af_en(af_en),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .dir_out(dir_out_al), .btn_out(btn_out_al),
        .coin_out(coin_out_al), .dsw(dsw_al), .dsw_valid(dsw_valid_al)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (active-high view) ----------------
    int         edge_n;
    logic [7:0] m_dsw [DB];
    logic       m_valid;
    logic [NP*4-1:0]  m_dir;
    logic [NP*NB-1:0] m_btn;
    logic [NP-1:0]    m_coin;
    logic       s1 [NP];
    logic       s2 [NP];
    int         pstart [NP];
    int         free_at [NP];

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < DB; i++) m_dsw[i] = 8'hFF;
        m_valid = 1'b0;
        m_dir = '0;
        m_btn = '0;
        m_coin = '0;
        for (int p = 0; p < NP; p++) begin
            s1[p] = 1'b0; s2[p] = 1'b0; pstart[p] = -1000; free_at[p] = 0;
        end
    endtask

    task automatic model_step();
        int  m;
        bit  phase, l, r, u, d, raw, rise;
        m = edge_n;
        if (ioctl_wr && ioctl_index == 8'd254 && int'(ioctl_addr) < DB) begin
            m_dsw[int'(ioctl_addr)] = ioctl_dout;
            m_valid = 1'b1;
        end
        phase = ((m / AFD) % 2) == 1;
        for (int p = 0; p < NP; p++) begin
            r = joy[16*p+0]; l = joy[16*p+1]; d = joy[16*p+2]; u = joy[16*p+3];
            m_dir[4*p+0] = r && !l;
            m_dir[4*p+1] = l && !r;
            m_dir[4*p+2] = d && !u;
            m_dir[4*p+3] = u && !d;
            for (int b = 0; b < NB; b++) begin
                raw = joy[16*p+4+b];
                m_btn[p*NB+b] = af_en[p*NB+b] ? (raw && phase) : raw;
            end
            // A rise seen one edge after it was sampled starts a pulse if free.
            rise = s1[p] && !s2[p];
            if (rise && m >= free_at[p]) begin
                pstart[p]  = m;
                free_at[p] = m + CP + CL + 1;
            end
            m_coin[p] = (m >= pstart[p]) && (m <= pstart[p] + CP - 1);
            s2[p] = s1[p];
            s1[p] = joy[16*p+CB];
        end
        edge_n++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        logic [DB*8-1:0] e_dsw;
        logic [NP*4-1:0] e_dir_al;
        logic [NP*NB-1:0] e_btn_al;
        logic [NP-1:0]   e_coin_al;
        forever begin
            @(negedge clk);
            for (int i = 0; i < DB; i++) e_dsw[8*i +: 8] = m_dsw[i];
            e_dir_al  = ~m_dir;
            e_btn_al  = ~m_btn;
            e_coin_al = ~m_coin;
            chk("dsw", dsw, e_dsw);
            chk("dsw_valid", dsw_valid, m_valid);
            chk("dir", dir_out, m_dir);
            chk("btn", btn_out, m_btn);
            chk("coin", coin_out, m_coin);
            chk("dsw_al", dsw_al, e_dsw);
            chk("dsw_valid_al", dsw_valid_al, m_valid);
            chk("dir_al", dir_out_al, e_dir_al);
            chk("btn_al", btn_out_al, e_btn_al);
            chk("coin_al", coin_out_al, e_coin_al);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dip_wr(input logic [7:0] idx, input logic [26:0] addr, input logic [7:0] data);
        ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data;
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        logic [31:0] hist;
        logic [19:0] afh;
        int hi0, hi1, diff, rises0, ntrans, bad, last_t;
        logic pc0;

        tick(3);
        chk("rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_valid", dsw_valid, 0);
        chk("rst_outs", {dir_out, btn_out, coin_out}, 0);
        chk("rst_outs_al", {dir_out_al, btn_out_al, coin_out_al}, 64'hFFFF);
        reset_n = 1'b1;
        tick(2);

        // DIP capture
        dip_wr(8'd0, 27'd0, 8'h77);
        chk("dip_other_index_valid", dsw_valid, 0);
        dip_wr(8'd254, 27'd0, 8'h12);
        dip_wr(8'd254, 27'd1, 8'h34);
        dip_wr(8'd254, 27'd2, 8'h56);
        dip_wr(8'd254, 27'd9, 8'hAA);
        chk("dip_bytes", dsw, 64'hFFFF_FFFF_FF56_3412);
        chk("dip_valid", dsw_valid, 1);
        dip_wr(8'd0, 27'd0, 8'h77);
        chk("dip_other_index_keep", dsw, 64'hFFFF_FFFF_FF56_3412);

        // Directions
        joy[3:0] = 4'b0011; tick(1);
        chk("dir_lr_cancel", dir_out[3:0], 4'b0000);
        joy[3:0] = 4'b0010; tick(1);
        chk("dir_left", dir_out[3:0], 4'b0010);
        joy[19:16] = 4'b1101; tick(1);
        chk("dir_p1_ud_cancel", dir_out[7:4], 4'b0001);
        chk("dir_p1_al", dir_out_al[7:4], 4'b1110);
        joy = '0; tick(2);

        // Coin: edges at 0, 8 (dropped), 13 (accepted)
        hist = '0;
        for (int i = 0; i < 32; i++) begin
            hist[i] = coin_out[0];
            joy[CB] = (i <= 1) || (i == 8) || (i == 9) || (i == 13) || (i == 14);
            tick(1);
        end
        chk("coin_timeline", hist, 32'h0007_803C);

        // Coin held for 100 cycles on both players simultaneously
        hi0 = 0; hi1 = 0; diff = 0; rises0 = 0; pc0 = 1'b0;
        for (int i = 0; i < 110; i++) begin
            hi0 += int'(coin_out[0]);
            hi1 += int'(coin_out[1]);
            if (coin_out[0] != coin_out[1]) diff++;
            if (coin_out[0] && !pc0) rises0++;
            pc0 = coin_out[0];
            joy[CB]      = (i < 100);
            joy[16 + CB] = (i < 100);
            tick(1);
        end
        chk("coin_held_width_p0", hi0, 4);
        chk("coin_held_width_p1", hi1, 4);
        chk("coin_held_pulses", rises0, 1);
        chk("coin_p0_p1_aligned", diff, 0);

        // Autofire on P0 BTN0
        af_en[0] = 1'b1;
        joy[4] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            afh[i] = btn_out[0];
            tick(1);
        end
        ntrans = 0; bad = 0; last_t = -1;
        for (int i = 2; i < 20; i++) begin
            if (afh[i] != afh[i-1]) begin
                if (last_t >= 0 && (i - last_t) != 3) bad++;
                last_t = i;
                ntrans++;
            end
        end
        chk("af_transitions", ntrans, 6);
        chk("af_bad_gaps", bad, 0);
        for (int k = 0; k < 10; k++) begin
            if (btn_out[0]) break;
            tick(1);
        end
        chk("af_high_before_release", btn_out[0], 1);
        joy[4] = 1'b0; tick(1);
        chk("af_release", btn_out[0], 0);
        af_en[0] = 1'b0;

        // Non-autofire button follows raw input one cycle later
        joy[5] = 1'b1; tick(1);
        chk("btn1_follow_on", btn_out[1], 1);
        chk("btn1_follow_on_al", btn_out_al[1], 0);
        joy[5] = 1'b0; tick(1);
        chk("btn1_follow_off", btn_out[1], 0);
        tick(4);

        // Reset in the middle of a coin pulse
        joy[CB] = 1'b1; tick(3);
        chk("coin_mid_pulse", coin_out[0], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_coin", coin_out, 0);
        chk("async_rst_coin_al", coin_out_al, 2'b11);
        chk("async_rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("async_rst_valid", dsw_valid, 0);
        joy = '0;
        tick(2);
        reset_n = 1'b1;
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
